parallel_bus_pollable_memory: RTL and testbench



---
 rtl/parallel_bus_pollable_memory_pkg.sv | 22 ++
 rtl/RAM_inferred.sv | 24 ++
 rtl/bus_entry_3state.sv | 15 +
 rtl/parallel_bus_pollable_memory.sv | 144 ++++++++++++++
 tb/tb_parallel_bus_pollable_memory.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/parallel_bus_pollable_memory_pkg.sv
// Shared encodings for the parallel-bus memory endpoint: per-direction beat state machines
// and the width of the post-reset stretch counter.
package parallel_bus_pollable_memory_pkg;

    localparam int RESET_COUNT_WIDTH = 4;

    typedef enum logic [2:0] {
        W_HI      = 3'd0,
        W_HI_DONE = 3'd1,
        W_LO      = 3'd2,
        W_LO_DONE = 3'd3,
        W_STROBED = 3'd4
    } wstate_t;

    typedef enum logic [1:0] {
        R_HI      = 2'd0,
        R_HI_DONE = 2'd1,
        R_LO      = 2'd2,
        R_LO_DONE = 2'd3
    } rstate_t;

endpackage

// File: rtl/RAM_inferred.sv
// Simple dual-port RAM on one clock; write when write_enable, read data registered (1 cycle).
// No flow control: a write and a read can occur every cycle.
module RAM_inferred #(
    parameter int addr_width = 7,
    parameter int data_width = 14
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [addr_width-1:0] write_address,
    input  logic [data_width-1:0] write_data,
    input  logic [addr_width-1:0] read_address,
    output logic [data_width-1:0] read_data
);

    logic [data_width-1:0] mem [0:(1 << addr_width)-1];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        read_data <= mem[read_address];
    end

endmodule

// File: rtl/bus_entry_3state.sv
// Tri-state pad: drives value onto pad while drive=1, otherwise releases it; pad is always sampled.
// Purely combinational, no flow control.
module bus_entry_3state #(
    parameter int WIDTH = 7
) (
    inout  wire  [WIDTH-1:0] pad,
    input  logic             drive,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] sampled
);

    assign pad     = drive ? value : {WIDTH{1'bz}};
    assign sampled = pad;

endmodule

// File: rtl/parallel_bus_pollable_memory.sv
// Host-strobed parallel-bus slave: address beat, then hi/lo half-word beats into/out of a 2*WIDTH RAM.
// ack is enable delayed one cycle; the host paces everything, so there is no backpressure.
module parallel_bus_pollable_memory #(
    parameter int WIDTH = 7
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             read,
    input  logic             register_select,
    input  logic             enable,
    output logic             ack,
    output logic             lemo,
    output logic             other0,
    output logic             other1,
    output logic [7:0]       leds
);
    import parallel_bus_pollable_memory_pkg::*;

    logic                         ireset;
    logic [RESET_COUNT_WIDTH-1:0] reset_count;
    logic [WIDTH-1:0]             address;
    logic [WIDTH-1:0]             write_data_hi;
    logic [WIDTH-1:0]             write_data_lo;
    logic [WIDTH-1:0]             bus_out;
    logic [WIDTH-1:0]             bus_in;
    logic [2*WIDTH-1:0]           dout;
    logic                         write_strobe;
    wstate_t                      wstate;
    rstate_t                      rstate;

    logic address_beat;
    logic write_beat;
    logic read_beat;

    assign address_beat = enable && !read && !register_select;
    assign write_beat   = enable && !read &&  register_select;
    assign read_beat    = enable &&  read;

    bus_entry_3state #(.WIDTH(WIDTH)) u_pad (
        .pad     (bus),
        .drive   (read),
        .value   (bus_out),
        .sampled (bus_in)
    );

    RAM_inferred #(.addr_width(WIDTH), .data_width(2*WIDTH)) u_ram (
        .clock         (clock),
        .write_enable  (write_strobe),
        .write_address (address),
        .write_data    ({write_data_hi, write_data_lo}),
        .read_address  (address),
        .read_data     (dout)
    );

    // Hold the internal reset for a few cycles past the external one so the host side settles.
    always_ff @(posedge clock) begin
        if (reset) begin
            ireset      <= 1'b1;
            reset_count <= '0;
        end else if (ireset) begin
            reset_count <= reset_count + 1'b1;
            if (reset_count[RESET_COUNT_WIDTH-1]) begin
                ireset <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ireset) begin
            address       <= '0;
            write_data_hi <= '0;
            write_data_lo <= '0;
            bus_out       <= '0;
            wstate        <= W_HI;
            rstate        <= R_HI;
            ack           <= 1'b0;
            write_strobe  <= 1'b0;
        end else begin
            ack          <= enable;
            write_strobe <= 1'b0;
            if (address_beat) begin
                // A new address abandons any half-finished word in either direction.
                address <= bus_in;
                wstate  <= W_HI;
                rstate  <= R_HI;
            end else begin
                case (wstate)
                    W_HI: begin
                        if (write_beat) begin
                            write_data_hi <= bus_in;
                            wstate        <= W_HI_DONE;
                        end
                    end
                    W_HI_DONE: begin
                        if (!enable) wstate <= W_LO;
                    end
                    W_LO: begin
                        if (write_beat) begin
                            write_data_lo <= bus_in;
                            wstate        <= W_LO_DONE;
                        end
                    end
                    W_LO_DONE: begin
                        write_strobe <= 1'b1;
                        wstate       <= W_STROBED;
                    end
                    W_STROBED: begin
                        if (!enable) wstate <= W_HI;
                    end
                    default: wstate <= W_HI;
                endcase

                case (rstate)
                    R_HI: begin
                        if (read_beat) begin
                            bus_out <= dout[2*WIDTH-1:WIDTH];
                            rstate  <= R_HI_DONE;
                        end
                    end
                    R_HI_DONE: begin
                        if (!enable) rstate <= R_LO;
                    end
                    R_LO: begin
                        if (read_beat) begin
                            bus_out <= dout[WIDTH-1:0];
                            rstate  <= R_LO_DONE;
                        end
                    end
                    R_LO_DONE: begin
                        if (!enable) rstate <= R_HI;
                    end
                    default: rstate <= R_HI;
                endcase
            end
        end
    end

    assign lemo   = 1'b0;
    assign other0 = 1'b0;
    assign other1 = 1'b0;
    assign leds   = {ack, write_strobe, enable, register_select, read, 2'b00, ireset};

endmodule

// File: tb/tb_parallel_bus_pollable_memory.sv
// Directed bench for parallel_bus_pollable_memory: host-style beats with hand-computed expectations.
module tb_parallel_bus_pollable_memory;

    logic       clock = 1'b0;
    logic       reset;
    logic       read;
    logic       register_select;
    logic       enable;
    logic       tb_oe;
    logic [6:0] tb_bus;
    wire  [6:0] bus;
    logic       ack;
    logic       lemo;
    logic       other0;
    logic       other1;
    logic [7:0] leds;

    int n_cmp = 0;
    int n_bad = 0;

    assign bus = tb_oe ? tb_bus : 7'bzzzzzzz;

    always #10 clock = ~clock;

    parallel_bus_pollable_memory #(.WIDTH(7)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .read            (read),
        .register_select (register_select),
        .enable          (enable),
        .ack             (ack),
        .lemo            (lemo),
        .other0          (other0),
        .other1          (other1),
        .leds            (leds)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One host beat: enable high for 3 cycles, low for 3; samples taken on falling clock edges.
    task automatic beat(input logic rs, input logic rd, input logic [6:0] dat,
                        output logic [6:0] seen, output int strobes, output int first,
                        output logic [5:0] acks);
        strobes = 0;
        first   = -1;
        acks    = '0;
        seen    = '0;
        register_select = rs;
        read            = rd;
        tb_oe           = ~rd;
        tb_bus          = dat;
        for (int i = 0; i < 6; i++) begin
            enable = (i < 3);
            @(posedge clock);
            @(negedge clock);
            if (leds[6]) begin
                strobes++;
                if (first < 0) first = i;
            end
            acks[i] = ack;
            if (i == 2) seen = bus;
        end
    endtask

    task automatic write_word(input logic [6:0] addr, input logic [13:0] word, input string tag);
        logic [6:0] seen;
        int         s_a, s_h, s_l, f;
        logic [5:0] a;
        beat(1'b0, 1'b0, addr, seen, s_a, f, a);
        beat(1'b1, 1'b0, word[13:7], seen, s_h, f, a);
        beat(1'b1, 1'b0, word[6:0], seen, s_l, f, a);
        check({tag, "_strobes"}, s_a + s_h + s_l, 1);
    endtask

    task automatic read_word(input logic [6:0] addr, output logic [13:0] word);
        logic [6:0] hi, lo;
        int         s, f;
        logic [5:0] a;
        beat(1'b0, 1'b0, addr, hi, s, f, a);
        beat(1'b0, 1'b1, 7'h00, hi, s, f, a);
        beat(1'b0, 1'b1, 7'h00, lo, s, f, a);
        word = {hi, lo};
    endtask

    task automatic wait_cycles(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (leds[6]) strobes++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  seen;
        logic [13:0] word;
        logic [5:0]  acks;
        int          s, f, total;
        logic [13:0] words [4];
        int          ack_seen;

        words[0] = 14'h0934;
        words[1] = 14'h0B56;
        words[2] = 14'h0D78;
        words[3] = 14'h0F1A;

        reset           = 1'b1;
        read            = 1'b0;
        register_select = 1'b0;
        enable          = 1'b0;
        tb_oe           = 1'b1;
        tb_bus          = 7'h2A;

        // Reset and stretch window: internal reset visible for 9 cycles after reset falls.
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("ireset_%0d", i), leds[0], (i < 9) ? 1 : 0);
            if (ack) ack_seen++;
            if (i == 4) check("idle_bus_released", bus, 7'h2A);
            @(posedge clock);
        end
        @(negedge clock);
        check("idle_ack", ack_seen, 0);
        check("spare_outputs", {lemo, other0, other1, leds[2:1]}, 0);

        // Single write to 0x4C.
        beat(1'b0, 1'b0, 7'h4C, seen, s, f, acks);
        check("addr_bus_released", seen, 7'h4C);
        check("addr_strobes", s, 0);
        beat(1'b1, 1'b0, 7'h12, seen, s, f, acks);
        check("hi_strobes", s, 0);
        beat(1'b1, 1'b0, 7'h34, seen, s, f, acks);
        check("lo_strobes", s, 1);
        check("lo_strobe_cycle", f, 1);
        check("ack_follow", acks, 6'b000111);

        // Reads alternate hi, lo, hi.
        beat(1'b0, 1'b0, 7'h4C, seen, s, f, acks);
        beat(1'b0, 1'b1, 7'h00, seen, s, f, acks);
        check("read1_hi", seen, 7'h12);
        beat(1'b0, 1'b1, 7'h00, seen, s, f, acks);
        check("read2_lo", seen, 7'h34);
        beat(1'b0, 1'b1, 7'h00, seen, s, f, acks);
        check("read3_hi", seen, 7'h12);

        // Four consecutive words, then read all back.
        for (int k = 0; k < 4; k++) write_word(7'h4C + 7'(k), words[k], $sformatf("wr%0d", k));
        for (int k = 0; k < 4; k++) begin
            read_word(7'h4C + 7'(k), word);
            check($sformatf("rd_word_%0d", k), word, words[k]);
        end

        // Hi beat aborted by a new address beat.
        total = 0;
        beat(1'b0, 1'b0, 7'h4D, seen, s, f, acks); total += s;
        beat(1'b1, 1'b0, 7'h55, seen, s, f, acks); total += s;
        beat(1'b0, 1'b0, 7'h50, seen, s, f, acks); total += s;
        check("abort_strobes", total, 0);
        beat(1'b1, 1'b0, 7'h01, seen, s, f, acks); total += s;
        beat(1'b1, 1'b0, 7'h02, seen, s, f, acks); total += s;
        check("after_abort_strobes", total, 1);
        read_word(7'h50, word);
        check("abort_new_word", word, 14'h0082);
        read_word(7'h4D, word);
        check("abort_old_word", word, 14'h0B56);

        // Reset between hi and lo beats.
        total = 0;
        beat(1'b0, 1'b0, 7'h4E, seen, s, f, acks); total += s;
        beat(1'b1, 1'b0, 7'h7F, seen, s, f, acks); total += s;
        reset = 1'b1;
        wait_cycles(2, s); total += s;
        reset = 1'b0;
        wait_cycles(12, s); total += s;
        check("reset_mid_strobes", total, 0);
        check("reset_done", leds[0], 0);
        beat(1'b1, 1'b0, 7'h03, seen, s, f, acks);
        check("post_reset_hi_strobes", s, 0);
        beat(1'b1, 1'b0, 7'h04, seen, s, f, acks);
        check("post_reset_lo_strobes", s, 1);
        read_word(7'h00, word);
        check("post_reset_word", word, 14'h0184);
        read_word(7'h4E, word);
        check("reset_ram_kept", word, 14'h0D78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
